// File: rtl/comp_bist_pkg.sv
// Shared types and constants for the comparator BIST engine and its golden model.
`timescale 1ns/1ps
package comp_bist_pkg;
    localparam int COMP_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;
endpackage

// File: rtl/comp_expect.sv
// Combinational golden model of an unsigned W-bit magnitude comparator.
`timescale 1ns/1ps
module comp_expect
    import comp_bist_pkg::*;
#(
    parameter int W = COMP_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         exp_gt,
    output logic         exp_eq,
    output logic         exp_lt
);
    assign exp_gt = (a > b);
    assign exp_eq = (a == b);
    assign exp_lt = (a < b);
endmodule

// File: rtl/comp3_bist.sv
// Exhaustive BIST sweep for the magnitude comparator: drives every {a,b} pair,
// checks gt/eq/lt against the golden model, counts mismatches and keeps the first.
`timescale 1ns/1ps
module comp3_bist
    import comp_bist_pkg::*;
#(
    parameter int W = COMP_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [W-1:0]   a_o,
    output logic [W-1:0]   b_o,
    input  logic           gt_i,
    input  logic           eq_i,
    input  logic           lt_i,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*W:0]   err_cnt,
    output logic           first_err_valid,
    output logic [2*W-1:0] first_err_vec
);
    state_t           state, state_nxt;
    logic [2*W-1:0]   idx;
    logic             exp_gt, exp_eq, exp_lt;
    logic             mismatch;
    logic             idx_last;

    comp_expect #(.W(W)) u_expect (
        .a      (a_o),
        .b      (b_o),
        .exp_gt (exp_gt),
        .exp_eq (exp_eq),
        .exp_lt (exp_lt)
    );

    // The operand register is the index itself, so a is the upper half.
    assign a_o      = idx[2*W-1:W];
    assign b_o      = idx[W-1:0];
    assign idx_last = &idx;
    assign mismatch = ({gt_i, eq_i, lt_i} != {exp_gt, exp_eq, exp_lt});

    assign busy = (state == DRIVE) || (state == SAMPLE);
    assign pass = done && (err_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = DRIVE;
            DRIVE:      state_nxt = SAMPLE;
            SAMPLE:     state_nxt = idx_last ? DONE : DRIVE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Index, error count and first-error capture; flags are only looked at in SAMPLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx             <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            done            <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx             <= '0;
                        err_cnt         <= '0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= '0;
                        done            <= 1'b0;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= idx;
                        end
                    end
                    if (idx_last) begin
                        done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_comp3_bist.sv
// Directed bench for comp3_bist with a behavioural comparator that can inject faults.
`timescale 1ns/1ps
module tb_comp3_bist;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] a_o, b_o;
    logic       gt_i, eq_i, lt_i;
    logic       busy, done, pass;
    logic [6:0] err_cnt;
    logic       first_err_valid;
    logic [5:0] first_err_vec;

    // 0 golden, 1 gt stuck at 0, 2 eq stuck at 1, 3 gt/lt swapped
    int mode = 0;
    int asserts = 0;
    int failures = 0;
    int sweep_cycles;
    int order_bad;
    int busy_bad;
    logic [6:0] cnt_after_start;
    logic       fv_after_start;
    logic       done_after_start;

    always #5 clk = ~clk;

    always_comb begin
        gt_i = (a_o > b_o);
        eq_i = (a_o == b_o);
        lt_i = (a_o < b_o);
        case (mode)
            1: gt_i = 1'b0;
            2: eq_i = 1'b1;
            3: begin
                gt_i = (a_o < b_o);
                lt_i = (a_o > b_o);
            end
            default: ;
        endcase
    end

    comp3_bist #(.W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .a_o             (a_o),
        .b_o             (b_o),
        .gt_i            (gt_i),
        .eq_i            (eq_i),
        .lt_i            (lt_i),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_vec   (first_err_vec)
    );

    // Pulses start for one cycle and follows the sweep until done or a budget expires.
    // sweep_cycles counts cycles from the start cycle (1 = first cycle after the start edge).
    task automatic run_sweep(input int poke);
        logic [5:0] kv;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sweep_cycles = 1;
        order_bad = 0;
        busy_bad = 0;
        cnt_after_start  = err_cnt;
        fv_after_start   = first_err_valid;
        done_after_start = done;
        while (!done && sweep_cycles < 400) begin
            kv = 6'((sweep_cycles - 1) / 2);
            if ({a_o, b_o} != kv) order_bad++;
            if (!busy || pass) busy_bad++;
            start = (sweep_cycles == poke);
            @(posedge clk);
            #1;
            sweep_cycles++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        asserts++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        asserts++;
        if ({done, pass, first_err_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: done/pass/fv got %b want 000", {done, pass, first_err_valid});
        end
        asserts++;
        if ({a_o, b_o, err_cnt, first_err_vec} !== 19'd0) begin
            failures++;
            $display("FAIL reset_values: a=%0d b=%0d err=%0d fev=%0d want all 0", a_o, b_o, err_cnt, first_err_vec);
        end
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_golden;
        mode = 0;
        run_sweep(-1);
        asserts++;
        if (sweep_cycles != 129) begin
            failures++;
            $display("FAIL golden_latency: done after %0d cycles want 129", sweep_cycles);
        end
        asserts++;
        if (order_bad != 0) begin
            failures++;
            $display("FAIL golden_order: %0d cycles with wrong {a,b} want 0", order_bad);
        end
        asserts++;
        if (busy_bad != 0) begin
            failures++;
            $display("FAIL golden_busy: %0d cycles not busy or pass high want 0", busy_bad);
        end
        asserts++;
        if ({pass, busy, first_err_valid, err_cnt} !== {3'b100, 7'd0}) begin
            failures++;
            $display("FAIL golden_result: pass=%b busy=%b fv=%b err=%0d want 1 0 0 0", pass, busy, first_err_valid, err_cnt);
        end
        repeat (3) @(posedge clk);
        #1;
        asserts++;
        if ({done, pass, a_o, b_o} !== 8'b11_111_111) begin
            failures++;
            $display("FAIL done_hold: done=%b pass=%b a=%0d b=%0d want 1 1 7 7", done, pass, a_o, b_o);
        end
    endtask

    task automatic test_fault(input int m, input int want_cnt, input int want_vec, input string name);
        mode = m;
        run_sweep(-1);
        asserts++;
        if (err_cnt !== 7'(want_cnt)) begin
            failures++;
            $display("FAIL %s_cnt: got %0d want %0d", name, err_cnt, want_cnt);
        end
        asserts++;
        if (first_err_valid !== 1'b1 || first_err_vec !== 6'(want_vec)) begin
            failures++;
            $display("FAIL %s_first: valid=%b vec=%0d want 1 %0d", name, first_err_valid, first_err_vec, want_vec);
        end
        asserts++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            failures++;
            $display("FAIL %s_pass: done=%b pass=%b want 1 0", name, done, pass);
        end
    endtask

    task automatic test_reset_mid_sweep;
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        asserts++;
        if ({a_o, b_o} !== 6'd20 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_vector: {a,b}=%0d busy=%b want 20 1", {a_o, b_o}, busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        asserts++;
        if ({busy, done, pass, first_err_valid, a_o, b_o, err_cnt, first_err_vec} !== 23'd0) begin
            failures++;
            $display("FAIL mid_reset: busy=%b done=%b a=%0d b=%0d err=%0d want all 0", busy, done, a_o, b_o, err_cnt);
        end
        @(posedge clk);
        #1;
        asserts++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_idle: busy=%b want 0", busy);
        end
        run_sweep(-1);
        asserts++;
        if (sweep_cycles != 129 || pass !== 1'b1) begin
            failures++;
            $display("FAIL mid_rerun: cycles=%0d pass=%b want 129 1", sweep_cycles, pass);
        end
    endtask

    task automatic test_start_while_busy;
        mode = 0;
        run_sweep(30);
        asserts++;
        if (sweep_cycles != 129 || order_bad != 0) begin
            failures++;
            $display("FAIL busy_start: cycles=%0d order_bad=%0d want 129 0", sweep_cycles, order_bad);
        end
        asserts++;
        if (pass !== 1'b1) begin
            failures++;
            $display("FAIL busy_start_pass: got %b want 1", pass);
        end
    endtask

    task automatic test_rerun_after_fail;
        test_fault(1, 28, 8, "rerun_pre");
        mode = 0;
        run_sweep(-1);
        asserts++;
        if (cnt_after_start !== 7'd0 || fv_after_start !== 1'b0 || done_after_start !== 1'b0) begin
            failures++;
            $display("FAIL rerun_clear: err=%0d fv=%b done=%b want 0 0 0", cnt_after_start, fv_after_start, done_after_start);
        end
        asserts++;
        if (pass !== 1'b1 || err_cnt !== 7'd0 || first_err_valid !== 1'b0 || first_err_vec !== 6'd0) begin
            failures++;
            $display("FAIL rerun_pass: pass=%b err=%0d fv=%b vec=%0d want 1 0 0 0", pass, err_cnt, first_err_valid, first_err_vec);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_golden();
        test_fault(1, 28, 8, "stuck_gt0");
        test_fault(2, 56, 1, "stuck_eq1");
        test_fault(3, 56, 1, "swap_gt_lt");
        test_reset_mid_sweep();
        test_start_while_busy();
        test_rerun_after_fail();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule

// File: doc/comp3_bist.md
# comp3_bist

Built-in self-test engine for the 3-bit magnitude comparator (`comp3`). It drives every `{a,b}` operand pair into the comparator and checks the returned `gt`/`eq`/`lt` flags against an internal golden model. It counts mismatches and latches the first failing vector. It is the synthesizable driver/checker for the comparator's operand/flag interface and sits beside `comp3` in the datapath, started by a control strobe.

## Interface
- `W`, default 3: operand width. Vector space is 2^(2W).
- `clk` in 1: rising-edge clock; sole clock domain.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: begin a sweep. Honoured only in IDLE or DONE; ignored while busy.
- `a_o` out W: operand A to the comparator, registered.
- `b_o` out W: operand B to the comparator, registered.
- `gt_i` in 1: comparator A>B flag.
- `eq_i` in 1: comparator A==B flag.
- `lt_i` in 1: comparator A<B flag.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep complete. Level; held until the next `start` or `rst`.
- `pass` out 1: `done` && `err_cnt`==0.
- `err_cnt` out 2W+1: number of mismatching vectors. Cannot overflow.
- `first_err_valid` out 1: at least one mismatch recorded this sweep.
- `first_err_vec` out 2W: `{a,b}` of the first mismatching vector.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- Vector index `idx` is a 2W-bit register. `{a_o,b_o}` = `idx` at all times. Sweep order is idx = 0 … 2^(2W)−1, with a in the upper half.
- IDLE/DONE with `start`=1 → DRIVE. The same edge sets `idx`=0 and clears `err_cnt`, `first_err_valid`, `first_err_vec`, and `done`.
- DRIVE → SAMPLE unconditionally. This is a one-cycle settle for the combinational DUT.
- In SAMPLE, the expected flags are exp_gt=(a_o>b_o), exp_eq=(a_o==b_o), exp_lt=(a_o<b_o), all unsigned.
- A mismatch is any of the three flags differing from its expected value. It covers non-one-hot outputs and X/0 flags.
- On a mismatch: `err_cnt`++. If `first_err_valid`==0, latch `first_err_vec`=`idx` and set `first_err_valid`.
- SAMPLE with `idx` = all-ones → DONE. Otherwise `idx`++ and → DRIVE.
- DONE holds all results stable. `a_o`/`b_o` stay at the last vector.
- `busy` = state ∈ {DRIVE, SAMPLE}.
- Reset values: state IDLE, `a_o`=0, `b_o`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_err_valid`=0, `first_err_vec`=0.
- Reset mid-sweep aborts the sweep, with no partial results retained.
- `rst` and `start` in the same cycle: reset wins.

## Timing
- `start` high in cycle t (from IDLE) gives DRIVE of vector k in cycle t+1+2k and SAMPLE in cycle t+2+2k.
- For W=3: `busy` is high in cycles t+1 … t+128; `done`/`pass` rise at t+129. Sweep latency is 2·2^(2W)+1 cycles from the `start` edge.
- `err_cnt` and `first_err_*` update on the edge that ends the SAMPLE cycle.
- Flag inputs are sampled only in SAMPLE. Their values in DRIVE, IDLE, and DONE are don't-care.
- `pass` is registered or derived combinationally from registered `done` and `err_cnt`. It is never high while `busy`.

## Structure
- Shared package `comp_bist_pkg`: state enum (IDLE, DRIVE, SAMPLE, DONE) and default operand width constant `COMP_W`=3.
- One sub-module `comp_expect`: purely combinational golden model (W-bit a,b → exp_gt, exp_eq, exp_lt). It is reusable by benches.
- Top contains the FSM, index counter, error counter, and first-error capture.

## Test plan
- Golden `comp3` connected, pulse `start` → `done`=1 exactly 129 cycles after `start`, `pass`=1, `err_cnt`=0, `first_err_valid`=0. The bench also checks all 64 `{a_o,b_o}` values appear in order.
- DUT with `gt` stuck at 0 → `err_cnt`=28, `first_err_vec`=6'b001000 (a=1, b=0), `pass`=0.
- DUT with `eq` stuck at 1 → `err_cnt`=56, `first_err_vec`=6'b000001 (a=0, b=1).
- DUT with `gt`/`lt` swapped → `err_cnt`=56, `first_err_vec`=1.
- Assert `rst` during DRIVE of vector 20 → next cycle all outputs at reset values. A new `start` then completes a full sweep with `pass`=1.
- `start` pulsed while `busy` → ignored, with no cycle shift of the completion time. A `start` in DONE after a failing sweep clears `err_cnt`/`first_err_*` and reruns, ending with `pass`=1 on a golden DUT.
